// File: rtl/id_stage_hs_if.sv
// IF->ID, ID->EX and write-back signal bundle for the decode stage.
// master drives the stage inputs; slave is the decode stage itself.
interface id_stage_hs_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_opcode;
    logic [AW-1:0]   out_rd;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [XLEN-1:0] out_data1;
    logic [XLEN-1:0] out_data2;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     stall_cnt;

    modport master (
        output flush, in_valid, inst, in_pc, out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, out_opcode, out_rd, out_func3, out_func7,
               out_data1, out_data2, out_imm, out_pc, stall_cnt
    );

    modport slave (
        input  flush, in_valid, inst, in_pc, out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, out_opcode, out_rd, out_func3, out_func7,
               out_data1, out_data2, out_imm, out_pc, stall_cnt
    );
endinterface

// File: rtl/id_stage_hs.sv
// Decode stage: register file plus decode of one instruction into a registered ID/EX payload.
// Latency 1 cycle inst -> out_*; in_ready drops on EX backpressure and for one cycle on a load-use hazard.
module id_stage_hs #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic         clk,
    input  logic         rst,
    id_stage_hs_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [AW-1:0]   rd;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } idex_t;

    logic [XLEN-1:0] rf_q [NREG];
    idex_t           pay_q, pay_d, dec, nop;
    logic            vld_q, vld_d;
    logic [31:0]     stall_q, stall_d;

    logic [6:0]      opc;
    logic [AW-1:0]   rs1, rs2;
    logic            wb_wr;
    logic [XLEN-1:0] rd1, rd2;
    logic            use_rs1, use_rs2;
    logic            hazard, in_rdy, accept;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;

    assign opc   = bus.inst[6:0];
    assign rs1   = bus.inst[15 +: AW];
    assign rs2   = bus.inst[20 +: AW];
    assign wb_wr = bus.wb_en && (bus.wb_rd != '0);

    // Entry 0 is held at zero, so x0 needs no special case on the read side.
    always_comb begin
        rd1 = rf_q[rs1];
        rd2 = rf_q[rs2];
        if (BYPASS != 0 && wb_wr && bus.wb_rd == rs1) rd1 = bus.wb_data;
        if (BYPASS != 0 && wb_wr && bus.wb_rd == rs2) rd2 = bus.wb_data;
    end

    assign use_rs1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    assign use_rs2 = (opc == OP_REG) || (opc == OP_STORE) || (opc == OP_BRANCH);

    assign hazard = vld_q && (pay_q.opcode == OP_LOAD) && (pay_q.rd != '0) &&
                    ((use_rs1 && rs1 == pay_q.rd) || (use_rs2 && rs2 == pay_q.rd));
    assign in_rdy = (!vld_q || bus.out_ready) && !hazard && !rst;
    assign accept = bus.in_valid && in_rdy;

    // Every format fits a signed 32-bit value; widen by replicating bit 31.
    always_comb begin
        imm32 = '0;
        unique case (opc)
            OP_IMM, OP_LOAD, OP_JALR:
                imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
            OP_STORE:
                imm32 = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
            OP_BRANCH:
                imm32 = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                         bus.inst[30:25], bus.inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {bus.inst[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                         bus.inst[20], bus.inst[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        imm_x        = {XLEN{imm32[31]}};
        imm_x[31:0]  = imm32;
    end

    always_comb begin
        nop        = '0;
        nop.opcode = OP_IMM;

        dec        = '0;
        dec.opcode = opc;
        dec.rd     = bus.inst[7 +: AW];
        dec.func3  = bus.inst[14:12];
        dec.func7  = bus.inst[31:25];
        dec.data1  = rd1;
        dec.data2  = rd2;
        dec.imm    = imm_x;
        dec.pc     = bus.in_pc;
    end

    always_comb begin
        vld_d = vld_q;
        pay_d = pay_q;
        if (bus.flush) begin
            vld_d = 1'b0;
            pay_d = nop;
        end else if (accept) begin
            vld_d = 1'b1;
            pay_d = dec;
        end else if (bus.out_ready) begin
            vld_d = 1'b0;
        end
        stall_d = stall_q + {31'd0, bus.in_valid && hazard && !bus.flush};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            pay_q   <= nop;
            stall_q <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            vld_q   <= vld_d;
            pay_q   <= pay_d;
            stall_q <= stall_d;
            if (wb_wr) rf_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = vld_q;
    assign bus.out_opcode = pay_q.opcode;
    assign bus.out_rd     = pay_q.rd;
    assign bus.out_func3  = pay_q.func3;
    assign bus.out_func7  = pay_q.func7;
    assign bus.out_data1  = pay_q.data1;
    assign bus.out_data2  = pay_q.data2;
    assign bus.out_imm    = pay_q.imm;
    assign bus.out_pc     = pay_q.pc;
    assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_id_stage_hs.sv
// Bench for id_stage_hs: BYPASS=1 and BYPASS=0 instances share one stimulus stream and
// are compared every cycle against an instruction-level model, plus directed literal checks.
module tb_id_stage_hs;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, wb_en;
    logic [31:0] inst;
    logic [63:0] in_pc, wb_data;
    logic [4:0]  wb_rd;

    id_stage_hs_if #(.XLEN(64), .AW(5)) b1 ();
    id_stage_hs_if #(.XLEN(64), .AW(5)) b0 ();

    assign b1.flush = flush;      assign b0.flush = flush;
    assign b1.in_valid = in_valid; assign b0.in_valid = in_valid;
    assign b1.inst = inst;        assign b0.inst = inst;
    assign b1.in_pc = in_pc;      assign b0.in_pc = in_pc;
    assign b1.out_ready = out_ready; assign b0.out_ready = out_ready;
    assign b1.wb_en = wb_en;      assign b0.wb_en = wb_en;
    assign b1.wb_rd = wb_rd;      assign b0.wb_rd = wb_rd;
    assign b1.wb_data = wb_data;  assign b0.wb_data = wb_data;

    id_stage_hs #(.XLEN(64), .NREG(32), .BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    id_stage_hs #(.XLEN(64), .NREG(32), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // Instruction-level model: architectural registers plus the one-deep ID/EX slot.
    logic [63:0] m_rf [32];
    bit          mdl_ok = 1'b0;
    logic        e_vld;
    logic [6:0]  e_op, e_f7;
    logic [4:0]  e_rd;
    logic [2:0]  e_f3;
    logic [63:0] e_d1 [2];
    logic [63:0] e_d2 [2];
    logic [63:0] e_imm, e_pc;
    logic [31:0] e_stall;

    function automatic bit uses1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op == 7'h33 || op == 7'h23 || op == 7'h63;
    endfunction

    function automatic logic [63:0] sx(input logic [63:0] v, input int w);
        if (v[w-1]) return v - (64'd1 << w);
        return v;
    endfunction

    function automatic logic [63:0] m_imm(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67: return sx(64'(i[31:20]), 12);
            7'h23:               return sx(64'({i[31:25], i[11:7]}), 12);
            7'h63:               return sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
            7'h37, 7'h17:        return sx(64'(i[31:12]) << 12, 32);
            7'h6f:               return sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
            default:             return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rdval(input logic [4:0] idx, input int byp);
        if (idx == 5'd0) return 64'd0;
        if (byp == 1 && wb_en && wb_rd == idx) return wb_data;
        return m_rf[idx];
    endfunction

    task automatic set_nop();
        e_vld = 1'b0; e_op = 7'h13; e_rd = '0; e_f3 = '0; e_f7 = '0;
        e_d1[0] = '0; e_d1[1] = '0; e_d2[0] = '0; e_d2[1] = '0; e_imm = '0; e_pc = '0;
    endtask

    // One clock: compare DUT against model with current inputs, advance model, cross the edge.
    task automatic tick();
        logic [4:0] r1, r2;
        bit hz, rdy, acc;
        #1;
        r1  = inst[19:15];
        r2  = inst[24:20];
        hz  = e_vld && e_op == 7'h03 && e_rd != 5'd0 &&
              ((uses1(inst[6:0]) && r1 == e_rd) || (uses2(inst[6:0]) && r2 == e_rd));
        rdy = (!e_vld || out_ready) && !hz && !rst;
        acc = in_valid && rdy;
        if (mdl_ok) begin
            chk("b1.out_valid", b1.out_valid, e_vld);
            chk("b1.in_ready", b1.in_ready, rdy);
            chk("b1.opcode", b1.out_opcode, e_op);
            chk("b1.rd", b1.out_rd, e_rd);
            chk("b1.func3", b1.out_func3, e_f3);
            chk("b1.func7", b1.out_func7, e_f7);
            chk("b1.data1", b1.out_data1, e_d1[1]);
            chk("b1.data2", b1.out_data2, e_d2[1]);
            chk("b1.imm", b1.out_imm, e_imm);
            chk("b1.pc", b1.out_pc, e_pc);
            chk("b1.stall_cnt", b1.stall_cnt, e_stall);
            chk("b0.out_valid", b0.out_valid, e_vld);
            chk("b0.in_ready", b0.in_ready, rdy);
            chk("b0.data1", b0.out_data1, e_d1[0]);
            chk("b0.data2", b0.out_data2, e_d2[0]);
            chk("b0.stall_cnt", b0.stall_cnt, e_stall);
        end
        if (rst) begin
            mdl_ok  = 1'b1;
            set_nop();
            e_stall = '0;
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
        end else begin
            if (in_valid && hz && !flush) e_stall = e_stall + 1;
            if (flush) begin
                set_nop();
            end else if (acc) begin
                e_vld = 1'b1; e_op = inst[6:0]; e_rd = inst[11:7];
                e_f3 = inst[14:12]; e_f7 = inst[31:25];
                e_d1[1] = rdval(r1, 1); e_d1[0] = rdval(r1, 0);
                e_d2[1] = rdval(r2, 1); e_d2[0] = rdval(r2, 0);
                e_imm = m_imm(inst); e_pc = in_pc;
            end else if (out_ready) begin
                e_vld = 1'b0;
            end
            if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 11))
            0, 1, 2: op = 7'h03;
            3:       op = 7'h13;
            4, 5:    op = 7'h33;
            6:       op = 7'h23;
            7:       op = 7'h63;
            8:       op = 7'h37;
            9:       op = 7'h17;
            10:      op = 7'h6f;
            default: op = 7'h67;
        endcase
        r[6:0]   = op;
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; inst = 32'h13; in_pc = '0;
        tick(); tick();
        chk("rst_valid", b1.out_valid, 0);
        chk("rst_opcode", b1.out_opcode, 7'h13);
        chk("rst_stall", b1.stall_cnt, 0);
        chk("rst_data1", b1.out_data1, 0);
        rst = 1'b0;

        // write-back then addi x6,x5,-1
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234;
        tick();
        wb_en = 1'b0; inst = 32'hFFF28313; in_pc = 64'h1000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("addi_valid", b1.out_valid, 1);
        chk("addi_data1", b1.out_data1, 64'h1234);
        chk("addi_imm", b1.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", b1.out_rd, 6);
        chk("addi_pc", b1.out_pc, 64'h1000);

        // same-cycle write-back of x7 with add x8,x7,x0
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'hAA; inst = 32'h00038433; in_valid = 1'b1;
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        chk("byp1_data1", b1.out_data1, 64'hAA);
        chk("byp0_data1", b0.out_data1, 64'h0);

        // ld x9,0(x1) followed by dependent add x10,x9,x9
        inst = 32'h0000B483; in_valid = 1'b1;
        tick();
        inst = 32'h00948533;
        #1;
        chk("lu_in_ready_low", b1.in_ready, 0);
        tick();
        chk("lu_bubble", b1.out_valid, 0);
        chk("lu_stall", b1.stall_cnt, 1);
        #1;
        chk("lu_in_ready_back", b1.in_ready, 1);
        tick();
        chk("lu_add_valid", b1.out_valid, 1);
        chk("lu_add_opcode", b1.out_opcode, 7'h33);
        chk("lu_add_rd", b1.out_rd, 10);

        // EX backpressure for three cycles
        inst = 32'h00100613; in_pc = 64'h100;
        tick();
        out_ready = 1'b0; inst = 32'h00200693; in_pc = 64'h104;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", b1.in_ready, 0);
            tick();
            chk("bp_pc_held", b1.out_pc, 64'h100);
            chk("bp_valid", b1.out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next_pc", b1.out_pc, 64'h104);
        chk("bp_next_rd", b1.out_rd, 13);

        // flush while valid and accepting
        inst = 32'h00300713; in_pc = 64'h108; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", b1.out_valid, 0);
        chk("fl_opcode", b1.out_opcode, 7'h13);
        chk("fl_pc", b1.out_pc, 0);

        // write to x0 is ignored
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
        tick();
        wb_en = 1'b0; inst = 32'h000005B3; in_valid = 1'b1;
        tick();
        chk("x0_data1", b1.out_data1, 0);
        chk("x0_valid", b1.out_valid, 1);

        inst = 32'h800000B7;
        tick();
        chk("lui_imm", b1.out_imm, 64'hFFFF_FFFF_8000_0000);
        inst = 32'hFFDFF0EF;
        tick();
        chk("jal_imm", b1.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        in_valid = 1'b0;
        tick();

        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = {$urandom, $urandom};
            inst      = rand_inst();
            in_pc     = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_stage_hs.md
Name: id_stage_hs

Overview:
- Parametrised successor decode stage for the RISC-V pipeline.
- Holds the register file and decodes one instruction per cycle into a registered ID/EX payload, including the sign-extended immediate.
- Adds what the previous decode stage lacked: XLEN and register-count parameters, valid/ready handshakes on both sides, write-back-to-read bypass, a one-bubble load-use interlock, synchronous flush, and a stall counter.
- Sits between IF (upstream) and EX (downstream).

Parameters:
XLEN, 64, datapath width; 32 or 64 only
NREG, 32, architectural registers; power of two, AW = log2(NREG)
BYPASS, 1, 1 = same-cycle write-back forwarded to register reads; 0 = read old RF value

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of held and incoming instruction
in_valid  in  1  IF presents an instruction
in_ready  out  1  ID accepts an instruction this cycle
inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  ID/EX payload valid
out_ready  in  1  EX accepts the payload
out_opcode  out  7  inst[6:0]
out_rd  out  AW  inst[11:7] (low AW bits)
out_func3  out  3  inst[14:12]
out_func7  out  7  inst[31:25]
out_data1  out  XLEN  rs1 value
out_data2  out  XLEN  rs2 value
out_imm  out  XLEN  sign-extended immediate
out_pc  out  XLEN  registered in_pc
wb_en  in  1  write-back strobe
wb_rd  in  AW  write-back register
wb_data  in  XLEN  write-back value
stall_cnt  out  32  count of load-use stall cycles

Behaviour:
- Reset (rst=1 at a clock edge):
  - all RF entries are 0; out_valid=0; stall_cnt=0.
  - payload is NOP: opcode 7'b0010011; rd, func3, func7, data1, data2, imm and pc all 0.
  - Reset overrides flush, wb_en and any handshake in the same cycle.
- Register file:
  - Written at posedge when wb_en=1 and wb_rd!=0. Register 0 always reads 0 and is never written.
  - Read is combinational from inst[19:15] and inst[24:20] (low AW bits).
  - With BYPASS=1, if wb_en=1, wb_rd!=0 and wb_rd equals the source index, the read returns wb_data.
- Decode use flags:
  - rs1 used for every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 used only for R 0110011, S 0100011 and B 1100011.
- Load-use hazard:
  - hazard = out_valid & (out_opcode==0000011) & (out_rd!=0) & ((rs1 used & rs1==out_rd) | (rs2 used & rs2==out_rd)).
- Handshake:
  - in_ready = (!out_valid | out_ready) & !hazard & !rst.
  - Accept = in_valid & in_ready.
  - On accept: payload registers load and out_valid=1 next cycle. Latency is 1 cycle, inst to out_*.
  - If out_valid & out_ready & !accept: out_valid=0 next cycle; this is the bubble.
  - If out_valid & !out_ready: payload holds stable and out_valid stays 1.
- Stall counter:
  - stall_cnt increments by 1 in each cycle where in_valid & hazard & !flush.
  - Wraps modulo 2^32.
- Immediate, sign bit inst[31], extended to XLEN:
  - I (0010011, 0000011, 1100111): inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U (LUI, AUIPC): {inst[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode (including R): 0.
- Flush:
  - Next cycle out_valid=0 and the payload is the NOP value.
  - Any instruction accepted in the flush cycle is discarded.
  - in_ready is not gated by flush; IF must drop its own instruction.
  - RF write-back still occurs in the flush cycle.
- Simultaneous write-back and read of the same register: governed by BYPASS, as above.

Test Plan:
- Reset, then write-back x5=64'h1234 (wb_en=1, wb_rd=5); next cycle send addi x6,x5,-1 (inst 32'hFFF28313) -> out_data1=64'h1234, out_imm=64'hFFFF_FFFF_FFFF_FFFF, out_rd=6, out_valid=1 one cycle later.
- Write-back x7=64'hAA and issue add x8,x7,x0 in the same cycle, BYPASS=1 -> out_data1=64'hAA. Repeat with BYPASS=0 -> out_data1 = old x7 = 0.
- ld x9,0(x1) accepted, then add x10,x9,x9 offered with out_ready=1 -> in_ready=0 for exactly 1 cycle, one out_valid=0 bubble, stall_cnt=1, add accepted the following cycle.
- out_ready held 0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0, no instruction lost or duplicated.
- Flush asserted while out_valid=1 and a new instruction is accepted -> next cycle out_valid=0, out_opcode=7'b0010011.
- Write-back wb_rd=0 with wb_data=64'hFF, then read x0 -> out_data1=0.
- Decode lui x1,0x80000 (inst 32'h800000B7) with XLEN=64 -> out_imm=64'hFFFF_FFFF_8000_0000.
- Decode jal x1,-4 (inst 32'hFFDFF0EF) -> out_imm=64'hFFFF_FFFF_FFFF_FFFC.
